// File: rtl/kernel_ctrl_pkg.sv
// rtl/kernel_ctrl_pkg.sv - shared state encoding, defaults and width helper for kernel_run_ctrl
package kernel_ctrl_pkg;

    localparam int DEF_GAP_CYCLES     = 16;
    localparam int DEF_TIMEOUT_CYCLES = 16777216;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_GAP       = 3'd3,
        S_ERROR     = 3'd4
    } run_state_e;

    // Bits needed to hold values below `value`, never less than one.
    function automatic int clog2_min1(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) width++;
        return width;
    endfunction

endpackage

// File: rtl/kernel_run_ctrl_if.sv
// rtl/kernel_run_ctrl_if.sv - ap_ctrl_hs handshake bundle between sequencer and HLS kernel
interface kernel_run_ctrl_if;

    logic ap_start;
    logic ap_ready;
    logic ap_done;
    logic ap_idle;

    modport master (output ap_start, input ap_ready, input ap_done, input ap_idle);
    modport slave  (input ap_start, output ap_ready, output ap_done, output ap_idle);

endinterface

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - N-stage level synchroniser with rising-edge pulse on the synchronised level
module sync_edge_det #(
    parameter int SYNC_STAGES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic level_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/kernel_run_ctrl.sv
// rtl/kernel_run_ctrl.sv - campaign sequencer driving an ap_ctrl_hs kernel with latency, run count and watchdog
module kernel_run_ctrl
    import kernel_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES    = 3,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int RUN_CNT_WIDTH  = 16,
    parameter int LAT_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    input  logic                     trigger,
    input  logic [RUN_CNT_WIDTH-1:0] num_runs,
    kernel_run_ctrl_if.master        kif,
    output logic                     busy,
    output logic [RUN_CNT_WIDTH-1:0] run_cnt,
    output logic [LAT_WIDTH-1:0]     last_latency,
    output logic                     campaign_done,
    output logic                     timeout_err
);

    localparam int                     GAP_W       = clog2_min1(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0]       GAP_LAST    = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
    localparam logic [GAP_W-1:0]       GAP_ONE     = GAP_W'(1);
    localparam logic [LAT_WIDTH-1:0]   LAT_ONE     = LAT_WIDTH'(1);
    localparam logic [LAT_WIDTH-1:0]   TIMEOUT_LAT = LAT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [RUN_CNT_WIDTH:0] RUN_ONE     = (RUN_CNT_WIDTH + 1)'(1);

    run_state_e               state_q, state_d;
    logic [RUN_CNT_WIDTH-1:0] runs_tgt_q, runs_tgt_d;
    logic [RUN_CNT_WIDTH-1:0] run_cnt_q, run_cnt_d;
    logic [LAT_WIDTH-1:0]     lat_q, lat_d;
    logic [LAT_WIDTH-1:0]     last_lat_q, last_lat_d;
    logic [GAP_W-1:0]         gap_q, gap_d;
    logic                     busy_q, busy_d;
    logic                     cdone_q, cdone_d;
    logic                     tmo_q, tmo_d;

    logic                     trig_s;
    logic                     trig_rise;
    logic [RUN_CNT_WIDTH:0]   run_next_wide;
    logic [LAT_WIDTH-1:0]     lat_inc;
    logic                     more_runs;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_trig_sync (
        .clk     (ap_clk),
        .rst     (ap_rst),
        .async_i (trigger),
        .level_o (trig_s),
        .rise_o  (trig_rise)
    );

    // One bit wider than run_cnt so the "more runs" compare is immune to wrap.
    assign run_next_wide = {1'b0, run_cnt_q} + RUN_ONE;
    assign lat_inc       = (lat_q == '1) ? lat_q : lat_q + LAT_ONE;
    assign more_runs     = (runs_tgt_q != '0) ? (run_next_wide < {1'b0, runs_tgt_q}) : trig_s;

    always_comb begin
        state_d    = state_q;
        runs_tgt_d = runs_tgt_q;
        run_cnt_d  = run_cnt_q;
        lat_d      = lat_q;
        last_lat_d = last_lat_q;
        gap_d      = gap_q;
        busy_d     = busy_q;
        cdone_d    = 1'b0;
        tmo_d      = tmo_q;

        case (state_q)
            S_IDLE: begin
                if (trig_rise && kif.ap_idle) begin
                    runs_tgt_d = num_runs;
                    run_cnt_d  = '0;
                    busy_d     = 1'b1;
                    tmo_d      = 1'b0;
                    lat_d      = LAT_ONE;
                    state_d    = S_START;
                end
            end
            S_START, S_WAIT_DONE: begin
                // ap_done takes precedence so a ready+done cycle completes the run once.
                if (kif.ap_done) begin
                    last_lat_d = lat_q;
                    run_cnt_d  = run_next_wide[RUN_CNT_WIDTH-1:0];
                    if (more_runs) begin
                        if (GAP_CYCLES == 0) begin
                            lat_d   = LAT_ONE;
                            state_d = S_START;
                        end else begin
                            gap_d   = '0;
                            state_d = S_GAP;
                        end
                    end else begin
                        busy_d  = 1'b0;
                        cdone_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (lat_q >= TIMEOUT_LAT) begin
                    tmo_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_ERROR;
                end else begin
                    lat_d = lat_inc;
                    if (state_q == S_START && kif.ap_ready) begin
                        state_d = S_WAIT_DONE;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    lat_d   = LAT_ONE;
                    state_d = S_START;
                end else begin
                    gap_d = gap_q + GAP_ONE;
                end
            end
            S_ERROR: begin
                if (!trig_s) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q    <= S_IDLE;
            runs_tgt_q <= '0;
            run_cnt_q  <= '0;
            lat_q      <= '0;
            last_lat_q <= '0;
            gap_q      <= '0;
            busy_q     <= 1'b0;
            cdone_q    <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            runs_tgt_q <= runs_tgt_d;
            run_cnt_q  <= run_cnt_d;
            lat_q      <= lat_d;
            last_lat_q <= last_lat_d;
            gap_q      <= gap_d;
            busy_q     <= busy_d;
            cdone_q    <= cdone_d;
            tmo_q      <= tmo_d;
        end
    end

    assign kif.ap_start  = (state_q == S_START);
    assign busy          = busy_q;
    assign run_cnt       = run_cnt_q;
    assign last_latency  = last_lat_q;
    assign campaign_done = cdone_q;
    assign timeout_err   = tmo_q;

endmodule

// File: tb/tb_kernel_run_ctrl.sv
// tb/tb_kernel_run_ctrl.sv - directed bench with kernel model and completion scoreboard for kernel_run_ctrl
module tb_kernel_run_ctrl;

    typedef struct {
        int lat;
        int cnt;
    } exp_t;

    logic        ap_clk;
    logic        ap_rst;
    logic        trigger;
    logic [15:0] num_runs;
    logic        busy;
    logic [15:0] run_cnt;
    logic [31:0] last_latency;
    logic        campaign_done;
    logic        timeout_err;

    kernel_run_ctrl_if kif ();

    kernel_run_ctrl #(
        .SYNC_STAGES    (3),
        .GAP_CYCLES     (16),
        .RUN_CNT_WIDTH  (16),
        .LAT_WIDTH      (32),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .ap_clk        (ap_clk),
        .ap_rst        (ap_rst),
        .trigger       (trigger),
        .num_runs      (num_runs),
        .kif           (kif),
        .busy          (busy),
        .run_cnt       (run_cnt),
        .last_latency  (last_latency),
        .campaign_done (campaign_done),
        .timeout_err   (timeout_err)
    );

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   start_count = 0;
    int   start_hi = 0;
    int   model_runs = 0;
    int   cd_count = 0;
    int   ready_at = 3;
    int   done_at = 10;
    int   k = 0;
    int   t0 = 0;
    bit   running = 0;
    bit   hold_busy = 0;
    bit   kern_abort = 0;
    bit   stray_done = 0;
    int   starts_q[$];
    int   dones_q[$];
    exp_t sb_q[$];

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    always @(posedge ap_clk) cyc <= cyc + 1;

    always @(negedge ap_clk) if (campaign_done === 1'b1) cd_count++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Kernel model: ready/done at fixed offsets (1-based) after ap_start is first seen.
    initial begin
        kif.ap_ready = 1'b0;
        kif.ap_done  = 1'b0;
        kif.ap_idle  = 1'b1;
        forever begin
            @(negedge ap_clk);
            kif.ap_ready = 1'b0;
            kif.ap_done  = 1'b0;
            if (ap_rst || kern_abort) begin
                running    = 1'b0;
                k          = 0;
                kern_abort = 1'b0;
            end else begin
                if (running && k == done_at) running = 1'b0;
                if (running) begin
                    k++;
                end else if (kif.ap_start === 1'b1) begin
                    running = 1'b1;
                    k       = 1;
                    start_count++;
                    starts_q.push_back(cyc);
                end
                if (running && kif.ap_start === 1'b1) start_hi++;
                if (running && k == ready_at) kif.ap_ready = 1'b1;
                if (running && k == done_at) begin
                    kif.ap_done = 1'b1;
                    model_runs++;
                    dones_q.push_back(cyc);
                    sb_q.push_back('{lat: k, cnt: model_runs});
                end
                if (!running && stray_done) begin
                    kif.ap_done = 1'b1;
                    stray_done  = 1'b0;
                end
            end
            kif.ap_idle = !running && !hold_busy;
        end
    end

    // Scoreboard: every nonzero change of run_cnt is one completion to pop and check.
    initial begin
        logic [15:0] prev_cnt;
        exp_t        e;
        prev_cnt = '0;
        forever begin
            @(negedge ap_clk);
            if (run_cnt !== prev_cnt) begin
                if (run_cnt != 16'd0) begin
                    if (sb_q.size() == 0) begin
                        check("sb_unexpected", run_cnt, prev_cnt);
                    end else begin
                        e = sb_q.pop_front();
                        check("sb_latency", last_latency, e.lat);
                        check("sb_run_cnt", run_cnt, e.cnt);
                    end
                end
                prev_cnt = run_cnt;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench time limit");
    end

    task automatic tick();
        @(negedge ap_clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_busy(input logic lvl, input int budget, input string tag);
        int n;
        n = 0;
        while (busy !== lvl && n < budget) begin
            tick();
            n++;
        end
        check(tag, busy, lvl);
    endtask

    task automatic run_campaign(input int nr, input string tag);
        trigger = 1'b0;
        wait_cycles(6);
        model_runs = 0;
        starts_q.delete();
        dones_q.delete();
        num_runs = 16'(nr);
        trigger  = 1'b1;
        t0       = cyc;
        wait_busy(1'b1, 20, tag);
    endtask

    initial begin
        int snap_hi, snap_cd, snap_start, s, n, fall_cyc;
        ap_rst   = 1'b1;
        trigger  = 1'b0;
        num_runs = '0;
        repeat (2) @(negedge ap_clk);
        #1;
        check("rst_ap_start", kif.ap_start, 0);
        check("rst_busy", busy, 0);
        check("rst_run_cnt", run_cnt, 0);
        check("rst_last_latency", last_latency, 0);
        check("rst_campaign_done", campaign_done, 0);
        check("rst_timeout_err", timeout_err, 0);
        ap_rst = 1'b0;
        wait_cycles(3);

        // 1: single run
        snap_hi = start_hi; snap_cd = cd_count;
        run_campaign(1, "t1_busy_rise");
        wait_busy(1'b0, 100, "t1_busy_fall");
        wait_cycles(2);
        check("t1_start_delay", (starts_q.size() > 0) ? starts_q[0] - t0 : -1, 4);
        check("t1_start_width", start_hi - snap_hi, 3);
        check("t1_run_cnt", run_cnt, 1);
        check("t1_last_latency", last_latency, 10);
        check("t1_campaign_done", cd_count - snap_cd, 1);

        // stray ap_done while idle is ignored
        stray_done = 1'b1;
        wait_cycles(3);
        check("stray_run_cnt", run_cnt, 1);
        check("stray_latency", last_latency, 10);

        // trigger edge while kernel not idle is dropped, not queued
        snap_start = start_count;
        hold_busy = 1'b1;
        trigger   = 1'b0;
        wait_cycles(6);
        trigger = 1'b1;
        wait_cycles(12);
        check("noidle_busy", busy, 0);
        hold_busy = 1'b0;
        wait_cycles(12);
        check("noidle_not_queued", busy, 0);
        check("noidle_starts", start_count - snap_start, 0);

        // 2: five runs with 16-cycle gap
        snap_cd = cd_count;
        run_campaign(5, "t2_busy_rise");
        wait_busy(1'b0, 400, "t2_busy_fall");
        wait_cycles(2);
        check("t2_starts", starts_q.size(), 5);
        for (int i = 1; i < 5; i++) begin
            if (i < starts_q.size() && i - 1 < dones_q.size())
                check($sformatf("t2_gap_%0d", i), starts_q[i] - dones_q[i-1], 17);
        end
        check("t2_run_cnt", run_cnt, 5);
        check("t2_campaign_done", cd_count - snap_cd, 1);

        // 3: continuous, trigger dropped during a run
        snap_cd = cd_count;
        run_campaign(0, "t3_busy_rise");
        wait_cycles(200);
        snap_start = start_count;
        n = 0;
        while (start_count == snap_start && n < 60) begin
            tick();
            n++;
        end
        check("t3_run_seen", start_count - snap_start, 1);
        trigger = 1'b0;
        wait_busy(1'b0, 100, "t3_busy_fall");
        fall_cyc = cyc;
        check("t3_busy_fall_cycle", fall_cyc, (dones_q.size() > 0) ? dones_q[dones_q.size()-1] + 1 : -1);
        check("t3_inflight_done", dones_q.size(), starts_q.size());
        check("t3_run_cnt", run_cnt, dones_q.size());
        snap_start = start_count;
        wait_cycles(40);
        check("t3_no_more_start", start_count - snap_start, 0);
        check("t3_campaign_done", cd_count - snap_cd, 1);

        // 4: ready and done in the first ap_start cycle
        ready_at = 1; done_at = 1;
        snap_hi = start_hi;
        run_campaign(1, "t4_busy_rise");
        wait_busy(1'b0, 50, "t4_busy_fall");
        wait_cycles(2);
        check("t4_start_width", start_hi - snap_hi, 1);
        check("t4_run_cnt", run_cnt, 1);
        check("t4_last_latency", last_latency, 1);

        // 5: watchdog
        ready_at = 3; done_at = 1000;
        snap_cd = cd_count;
        run_campaign(1, "t5_busy_rise");
        tick();
        s = (starts_q.size() > 0) ? starts_q[0] : cyc;
        n = 0;
        while (cyc < s + 63 && n < 100) begin
            tick();
            n++;
        end
        check("t5_pre_timeout", timeout_err, 0);
        check("t5_pre_busy", busy, 1);
        tick();
        check("t5_timeout_err", timeout_err, 1);
        check("t5_ap_start", kif.ap_start, 0);
        check("t5_busy", busy, 0);
        wait_cycles(5);
        check("t5_error_hold", kif.ap_start, 0);
        check("t5_no_campaign_done", cd_count - snap_cd, 0);
        kern_abort = 1'b1;
        trigger    = 1'b0;
        wait_cycles(8);
        check("t5_sticky", timeout_err, 1);
        done_at = 10;
        run_campaign(1, "t5_restart_busy");
        check("t5_cleared", timeout_err, 0);
        wait_busy(1'b0, 100, "t5_restart_end");
        check("t5_restart_run_cnt", run_cnt, 1);

        // 6: reset during WAIT_DONE of the second run
        run_campaign(3, "t6_busy_rise");
        n = 0;
        while (starts_q.size() < 2 && n < 100) begin
            tick();
            n++;
        end
        wait_cycles(4);
        check("t6_pre_run_cnt", run_cnt, 1);
        ap_rst = 1'b1;
        #1;
        check("t6_rst_ap_start", kif.ap_start, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_run_cnt", run_cnt, 0);
        check("t6_rst_latency", last_latency, 0);
        check("t6_rst_campaign_done", campaign_done, 0);
        check("t6_rst_timeout", timeout_err, 0);
        trigger = 1'b0;
        wait_cycles(3);
        ap_rst = 1'b0;
        snap_cd = cd_count;
        run_campaign(1, "t6_clean_busy");
        wait_busy(1'b0, 100, "t6_clean_end");
        wait_cycles(2);
        check("t6_clean_run_cnt", run_cnt, 1);
        check("t6_clean_campaign_done", cd_count - snap_cd, 1);
        check("t6_clean_latency", last_latency, 10);

        wait_cycles(3);
        check("sb_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
